// File: rtl/iot_bus_mux_pkg.sv
// Shared IOT bus constants: CPU major-state codes, instruction field widths
// and the bus-mux FSM encoding.
package iot_bus_mux_pkg;

    localparam logic [4:0] F1 = 5'd1;
    localparam logic [4:0] F2 = 5'd2;
    localparam logic [4:0] F3 = 5'd3;

    localparam logic [2:0] IOT_OP = 3'o6;
    localparam int         DEV_W  = 6;
    localparam int         WORD_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } fsm_t;

endpackage

// File: rtl/iot_bus_mux_if.sv
// CPU-side and device-side IOT bus signals; master is the mux, slave is the
// CPU/device side that drives requests and consumes results.
interface iot_bus_mux_if #(
    parameter int NDEV = 4
) ();
    logic [4:0]         state;
    logic [0:11]        instruction;
    logic [0:11]        ac;
    logic               int_enable;
    logic [NDEV*12-1:0] dev_data;
    logic [NDEV-1:0]    dev_skip;
    logic [NDEV-1:0]    dev_clr_ac;
    logic [NDEV-1:0]    dev_ack;
    logic [NDEV-1:0]    dev_irq;
    logic [NDEV-1:0]    dev_sel;
    logic [2:0]         iop;
    logic               stall;
    logic               skip;
    logic               clr_ac;
    logic [0:11]        in_bus;
    logic [0:11]        bus_display;
    logic               irq;
    logic [3:0]         irq_dev;
    logic               timeout_err;

    modport master (
        input  state, instruction, ac, int_enable,
        input  dev_data, dev_skip, dev_clr_ac, dev_ack, dev_irq,
        output dev_sel, iop, stall, skip, clr_ac, in_bus, bus_display,
        output irq, irq_dev, timeout_err
    );

    modport slave (
        output state, instruction, ac, int_enable,
        output dev_data, dev_skip, dev_clr_ac, dev_ack, dev_irq,
        input  dev_sel, iop, stall, skip, clr_ac, in_bus, bus_display,
        input  irq, irq_dev, timeout_err
    );
endinterface

// File: rtl/iot_bus_mux_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module iot_prio_enc #(
    parameter int N  = 4,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/iot_bus_mux.sv
// IOT bus multiplexer: decodes the device code, selects one channel, stalls
// the CPU for slow devices, and returns registered data/skip/clear-AC.
module iot_bus_mux
    import iot_bus_mux_pkg::*;
#(
    parameter int                NDEV      = 4,
    parameter logic [NDEV*6-1:0] DEV_CODES = {6'o22, 6'o00, 6'o04, 6'o03},
    parameter logic [NDEV-1:0]   SLOW_MASK = 4'b1000,
    parameter logic [NDEV-1:0]   DISP_SRC  = 4'b0001,
    parameter int                TIMEOUT   = 15,
    parameter int                CW        = 8
) (
    input logic          clk,
    input logic          reset,
    iot_bus_mux_if.master bus
);
    localparam int CH_W = (NDEV > 1) ? $clog2(NDEV) : 1;

    fsm_t st, st_nxt;

    logic [CH_W-1:0]   ch;
    logic [WORD_W-1:0] ac_q;
    logic [2:0]        iop_q;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_inc;

    logic [DEV_W-1:0]  dev_code;
    logic              is_iot;
    logic              at_f2;
    logic [NDEV-1:0]   match;
    logic [CH_W-1:0]   match_idx;
    logic              match_vld;
    logic [3:0]        irq_idx;
    logic              irq_vld;
    logic [WORD_W-1:0] rd_data;

    logic accept, capture, tmo, release_bus, unmatched, clr_tmo;

    logic [WORD_W-1:0] in_bus_q, disp_q;
    logic              skip_q, clr_ac_q, tmo_err_q, irq_q;
    logic [3:0]        irq_dev_q;

    assign dev_code = bus.instruction[3:8];
    assign is_iot   = (bus.instruction[0:2] == IOT_OP);
    assign at_f2    = (bus.state == F2);
    assign cnt_inc  = cnt + 1'b1;
    assign rd_data  = bus.dev_data[12*int'(ch) +: WORD_W];
    assign clr_tmo  = (st == IDLE) && at_f2 && (bus.instruction == 12'o6000);

    always_comb begin
        match = '0;
        for (int i = 0; i < NDEV; i++) begin
            match[i] = (DEV_CODES[6*i +: 6] == dev_code);
        end
    end

    iot_prio_enc #(.N(NDEV), .IW(CH_W)) u_match_enc (
        .req   (match),
        .idx   (match_idx),
        .valid (match_vld)
    );

    iot_prio_enc #(.N(NDEV), .IW(4)) u_irq_enc (
        .req   (bus.dev_irq),
        .idx   (irq_idx),
        .valid (irq_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) st <= IDLE;
        else       st <= st_nxt;
    end

    always_comb begin
        st_nxt      = st;
        accept      = 1'b0;
        capture     = 1'b0;
        tmo         = 1'b0;
        release_bus = 1'b0;
        unmatched   = 1'b0;
        case (st)
            IDLE: begin
                if (at_f2 && is_iot) begin
                    if (match_vld) begin
                        accept = 1'b1;
                        st_nxt = SEL;
                    end else begin
                        unmatched = 1'b1;
                    end
                end
            end
            SEL: begin
                if (!SLOW_MASK[ch]) begin
                    capture = 1'b1;
                    st_nxt  = DONE;
                end else begin
                    st_nxt  = WAIT;
                end
            end
            WAIT: begin
                // Ack is checked first so it beats a simultaneous timeout.
                if (bus.dev_ack[ch]) begin
                    capture = 1'b1;
                    st_nxt  = DONE;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    tmo    = 1'b1;
                    st_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.state == F1) begin
                    release_bus = 1'b1;
                    st_nxt      = IDLE;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    // Transaction context is latched on acceptance and never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            ch    <= match_idx;
            ac_q  <= bus.ac;
            iop_q <= bus.instruction[9:11];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            in_bus_q  <= '0;
            skip_q    <= 1'b0;
            clr_ac_q  <= 1'b0;
            disp_q    <= '0;
            tmo_err_q <= 1'b0;
            irq_q     <= 1'b0;
            irq_dev_q <= '0;
        end else begin
            if (st == SEL)       cnt <= '0;
            else if (st == WAIT) cnt <= cnt_inc;

            if (capture) begin
                in_bus_q <= rd_data;
                skip_q   <= bus.dev_skip[ch];
                clr_ac_q <= bus.dev_clr_ac[ch];
                disp_q   <= DISP_SRC[ch] ? rd_data : ac_q;
            end else if (tmo) begin
                in_bus_q  <= '0;
                skip_q    <= 1'b0;
                clr_ac_q  <= 1'b0;
                disp_q    <= DISP_SRC[ch] ? '0 : ac_q;
                tmo_err_q <= 1'b1;
            end else if (release_bus || unmatched) begin
                in_bus_q <= '0;
                skip_q   <= 1'b0;
                clr_ac_q <= 1'b0;
            end

            if (clr_tmo) tmo_err_q <= 1'b0;

            irq_q <= bus.int_enable & (|bus.dev_irq);
            if (irq_vld) irq_dev_q <= irq_idx;
        end
    end

    always_comb begin
        bus.dev_sel = '0;
        bus.iop     = '0;
        if (st == SEL || st == WAIT) begin
            bus.dev_sel[ch] = 1'b1;
            bus.iop         = iop_q;
        end
    end

    assign bus.stall       = (st == SEL) || (st == WAIT);
    assign bus.skip        = skip_q;
    assign bus.clr_ac      = clr_ac_q;
    assign bus.in_bus      = in_bus_q;
    assign bus.bus_display = disp_q;
    assign bus.irq         = irq_q;
    assign bus.irq_dev     = irq_dev_q;
    assign bus.timeout_err = tmo_err_q;
endmodule

// File: tb/tb_iot_bus_mux.sv
// Directed bench for iot_bus_mux: vector table for per-cycle behaviour plus
// hand-written sequences for fast, slow, timeout and reset transactions.
module tb_iot_bus_mux;
    import iot_bus_mux_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    iot_bus_mux_if #(.NDEV(4)) bus ();

    iot_bus_mux dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  st;
        logic [11:0] instr;
        logic        int_en;
        logic [3:0]  irq_in;
        logic [3:0]  exp_sel;
        logic        exp_stall;
        logic [11:0] exp_in_bus;
        logic [11:0] exp_disp;
        logic        exp_irq;
        logic [3:0]  exp_irq_dev;
    } vec_t;

    vec_t tbl[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0o, expected %0o", name, act, exp);
        end
    endtask

    task automatic check_all_zero();
        check("rst_sel", 32'(bus.dev_sel), 0);
        check("rst_iop", 32'(bus.iop), 0);
        check("rst_stall", 32'(bus.stall), 0);
        check("rst_skip", 32'(bus.skip), 0);
        check("rst_clr_ac", 32'(bus.clr_ac), 0);
        check("rst_in_bus", 32'(bus.in_bus), 0);
        check("rst_disp", 32'(bus.bus_display), 0);
        check("rst_irq", 32'(bus.irq), 0);
        check("rst_irq_dev", 32'(bus.irq_dev), 0);
        check("rst_tmo_err", 32'(bus.timeout_err), 0);
    endtask

    initial begin
        int n;
        // ch3=0070, ch2=1111, ch1=2222, ch0=0215
        tbl[0] = '{F2, 12'o6554, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'o0, 12'o0215, 1'b0, 4'd0};
        tbl[1] = '{F2, 12'o1234, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'o0, 12'o0215, 1'b0, 4'd0};
        tbl[2] = '{F3, 12'o7000, 1'b1, 4'b1010, 4'b0000, 1'b0, 12'o0, 12'o0215, 1'b1, 4'd1};
        tbl[3] = '{F3, 12'o7000, 1'b0, 4'b1010, 4'b0000, 1'b0, 12'o0, 12'o0215, 1'b0, 4'd1};
        tbl[4] = '{F3, 12'o7000, 1'b1, 4'b0000, 4'b0000, 1'b0, 12'o0, 12'o0215, 1'b0, 4'd1};
        tbl[5] = '{F3, 12'o7000, 1'b1, 4'b1100, 4'b0000, 1'b0, 12'o0, 12'o0215, 1'b1, 4'd2};
        tbl[6] = '{F3, 12'o7000, 1'b1, 4'b1000, 4'b0000, 1'b0, 12'o0, 12'o0215, 1'b1, 4'd3};
        tbl[7] = '{F2, 12'o6036, 1'b0, 4'b0000, 4'b0001, 1'b1, 12'o0, 12'o0215, 1'b0, 4'd3};
        tbl[8] = '{F3, 12'o6036, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'o0215, 12'o0215, 1'b0, 4'd3};
        tbl[9] = '{F1, 12'o7000, 1'b0, 4'b0000, 4'b0000, 1'b0, 12'o0, 12'o0215, 1'b0, 4'd3};

        reset           = 1'b1;
        bus.state       = F3;
        bus.instruction = 12'o7000;
        bus.ac          = 12'o0;
        bus.int_enable  = 1'b0;
        bus.dev_data    = {12'o0070, 12'o1111, 12'o2222, 12'o0215};
        bus.dev_skip    = 4'b1001;
        bus.dev_clr_ac  = 4'b0001;
        bus.dev_ack     = 4'b0000;
        bus.dev_irq     = 4'b0000;
        tick();
        tick();
        check_all_zero();
        reset = 1'b0;

        // Fast read on channel 0
        bus.state = F2; bus.instruction = 12'o6036; bus.ac = 12'o4321;
        tick();
        check("fast_sel", 32'(bus.dev_sel), 32'b0001);
        check("fast_iop", 32'(bus.iop), 32'o6);
        check("fast_stall", 32'(bus.stall), 1);
        bus.state = F3;
        tick();
        check("fast_sel_drop", 32'(bus.dev_sel), 0);
        check("fast_stall_drop", 32'(bus.stall), 0);
        check("fast_in_bus", 32'(bus.in_bus), 32'o0215);
        check("fast_skip", 32'(bus.skip), 1);
        check("fast_clr_ac", 32'(bus.clr_ac), 1);
        check("fast_disp", 32'(bus.bus_display), 32'o0215);
        tick();
        check("fast_hold", 32'(bus.in_bus), 32'o0215);
        bus.state = F1;
        tick();
        check("fast_release_in_bus", 32'(bus.in_bus), 0);
        check("fast_release_skip", 32'(bus.skip), 0);

        for (int i = 0; i < 10; i++) begin
            bus.state       = tbl[i].st;
            bus.instruction = tbl[i].instr;
            bus.int_enable  = tbl[i].int_en;
            bus.dev_irq     = tbl[i].irq_in;
            tick();
            check($sformatf("vec%0d_sel", i), 32'(bus.dev_sel), 32'(tbl[i].exp_sel));
            check($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'(tbl[i].exp_stall));
            check($sformatf("vec%0d_in_bus", i), 32'(bus.in_bus), 32'(tbl[i].exp_in_bus));
            check($sformatf("vec%0d_disp", i), 32'(bus.bus_display), 32'(tbl[i].exp_disp));
            check($sformatf("vec%0d_irq", i), 32'(bus.irq), 32'(tbl[i].exp_irq));
            check($sformatf("vec%0d_irq_dev", i), 32'(bus.irq_dev), 32'(tbl[i].exp_irq_dev));
        end
        bus.state = F3; bus.int_enable = 1'b0; bus.dev_irq = 4'b0000;

        // Slow channel 3, ack in the sixth WAIT cycle; stray ack on ch0 ignored
        bus.ac = 12'o1357; bus.state = F2; bus.instruction = 12'o6224;
        tick();
        check("slow_sel", 32'(bus.dev_sel), 32'b1000);
        check("slow_iop", 32'(bus.iop), 32'o4);
        n = bus.stall ? 1 : 0;
        bus.state = F3; bus.instruction = 12'o7777; bus.dev_ack = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.stall) n++;
        end
        check("slow_sel_held", 32'(bus.dev_sel), 32'b1000);
        check("slow_iop_held", 32'(bus.iop), 32'o4);
        bus.dev_ack = 4'b1000;
        tick();
        bus.dev_ack = 4'b0000;
        check("slow_stall_cycles", 32'(n), 7);
        check("slow_stall_drop", 32'(bus.stall), 0);
        check("slow_in_bus", 32'(bus.in_bus), 32'o0070);
        check("slow_skip", 32'(bus.skip), 1);
        check("slow_disp", 32'(bus.bus_display), 32'o1357);
        check("slow_tmo_err", 32'(bus.timeout_err), 0);
        bus.state = F1;
        tick();

        // Timeout on channel 3, bounded wait
        bus.ac = 12'o0777; bus.state = F2; bus.instruction = 12'o6224;
        tick();
        bus.state = F3;
        n = 0;
        for (int k = 0; k < 40 && bus.stall; k++) begin
            n++;
            tick();
        end
        check("tmo_stall_cycles", 32'(n), 16);
        check("tmo_in_bus", 32'(bus.in_bus), 0);
        check("tmo_skip", 32'(bus.skip), 0);
        check("tmo_clr_ac", 32'(bus.clr_ac), 0);
        check("tmo_err_set", 32'(bus.timeout_err), 1);
        check("tmo_disp", 32'(bus.bus_display), 32'o0777);
        bus.state = F1;
        tick();
        check("tmo_err_sticky", 32'(bus.timeout_err), 1);
        bus.state = F2; bus.instruction = 12'o6000;
        tick();
        check("tmo_err_clear", 32'(bus.timeout_err), 0);
        check("iot6000_sel", 32'(bus.dev_sel), 32'b0100);
        bus.state = F3;
        tick();
        check("iot6000_in_bus", 32'(bus.in_bus), 32'o1111);
        bus.state = F1;
        tick();

        // Ack arriving on the same edge the counter reaches TIMEOUT
        bus.ac = 12'o0123; bus.state = F2; bus.instruction = 12'o6224;
        tick();
        bus.state = F3;
        for (int k = 0; k < 15; k++) tick();
        check("race_still_waiting", 32'(bus.stall), 1);
        bus.dev_ack = 4'b1000;
        tick();
        bus.dev_ack = 4'b0000;
        check("race_in_bus", 32'(bus.in_bus), 32'o0070);
        check("race_tmo_err", 32'(bus.timeout_err), 0);
        check("race_stall", 32'(bus.stall), 0);
        bus.state = F1;
        tick();

        // Reset mid-WAIT with irq active
        bus.int_enable = 1'b1; bus.dev_irq = 4'b1000;
        bus.state = F2; bus.instruction = 12'o6224;
        tick();
        bus.state = F3;
        tick(); tick(); tick();
        check("pre_rst_stall", 32'(bus.stall), 1);
        check("pre_rst_irq", 32'(bus.irq), 1);
        reset = 1'b1;
        tick(); tick();
        check_all_zero();
        reset = 1'b0; bus.int_enable = 1'b0; bus.dev_irq = 4'b0000;
        tick();
        check("post_rst_sel", 32'(bus.dev_sel), 0);
        check("post_rst_stall", 32'(bus.stall), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/iot_bus_mux.md
Name: iot_bus_mux

Overview:
- Parametrised IOT bus multiplexer between the PDP-8e CPU and NDEV peripheral channels.
- Decodes the IOT device code and issues a one-hot device select plus the IOP bits.
- Optionally stalls the CPU until a slow device acknowledges or a timeout expires; returns registered data, skip and clear-AC to the CPU.
- Also aggregates interrupt requests and maintains the front-panel bus display.

Parameters:
- NDEV, 4: number of device channels (1..16).
- DEV_CODES, {6'o22,6'o00,6'o04,6'o03}: packed 6-bit device codes; channel i occupies bits [6i+5:6i].
- SLOW_MASK, 4'b1000: bit i set means channel i uses the dev_ack handshake.
- DISP_SRC, 4'b0001: bit i set means bus_display shows device data; clear means it shows the AC.
- TIMEOUT, 15: maximum WAIT cycles before abort (1..255).
- CW, 8: timeout counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- state  in  5  CPU major state; F1/F2/F3 encodings from parameters.v.
- instruction  in  [0:11]  current instruction.
- ac  in  [0:11]  accumulator.
- int_enable  in  1  CPU ION flag.
- dev_data  in  NDEV*12  packed device read data; channel i at [12i+11:12i].
- dev_skip  in  NDEV  per-channel skip condition.
- dev_clr_ac  in  NDEV  per-channel "clear AC before OR" request.
- dev_ack  in  NDEV  slow-device completion.
- dev_irq  in  NDEV  interrupt requests.
- dev_sel  out  NDEV  one-hot device select.
- iop  out  3  instruction[9:11], valid while dev_sel is non-zero.
- stall  out  1  CPU must hold state.
- skip  out  1  registered skip.
- clr_ac  out  1  registered clear-AC.
- in_bus  out  [0:11]  registered read data.
- bus_display  out  [0:11]  panel display.
- irq  out  1  interrupt request to the CPU.
- irq_dev  out  4  lowest-index requesting channel.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset: all outputs 0 (dev_sel, iop, stall, skip, clr_ac, in_bus, bus_display, irq, irq_dev, timeout_err). FSM goes to IDLE; counter clears.
- IOT detect: instruction[0:2]==3'o6. Device code is instruction[3:8].
- Match: channel i matches when its DEV_CODES field equals the device code. If several match, the lowest index wins (ch).
- FSM states: IDLE, SEL, WAIT, DONE.
- IDLE:
  - On an edge with state==F2, IOT, and a match: latch ch and ac, go to SEL.
  - IOT with no match: stay IDLE; clear skip, clr_ac and in_bus to 0 on that edge.
- SEL (one cycle):
  - dev_sel[ch]=1 and iop=instruction[9:11].
  - Fast channel (SLOW_MASK[ch]==0): on the SEL edge capture dev_data[ch], dev_skip[ch], dev_clr_ac[ch] into in_bus, skip, clr_ac; go to DONE.
  - Slow channel: go to WAIT and clear the counter.
- WAIT:
  - dev_sel[ch] is held; counter increments each cycle.
  - dev_ack[ch]=1: capture as in SEL, go to DONE. Ack wins if it arrives in the same cycle the counter reaches TIMEOUT.
  - Counter reaches TIMEOUT without ack: in_bus=0, skip=0, clr_ac=0, timeout_err<=1, go to DONE.
  - dev_ack on channels other than ch is ignored.
- stall: combinational, 1 while in SEL or WAIT and 0 otherwise. Fast-path latency: data is valid 2 cycles after the F2 edge, with 1 stall cycle.
- DONE:
  - dev_sel=0. in_bus, skip and clr_ac are held.
  - bus_display is updated once, on DONE entry: DISP_SRC[ch] ? captured data : latched ac. Timeout captures 0 when DISP_SRC[ch]=1.
  - Go to IDLE on an edge with state==F1. in_bus, skip and clr_ac are cleared on that same edge.
- timeout_err: cleared only by reset, or by IOT 6000 decoded in IDLE at F2.
- Interrupts:
  - irq <= int_enable & |dev_irq, registered every cycle regardless of FSM state.
  - irq_dev <= lowest set index, held when there are no requests.
- Reset asserted in any state: immediate return to reset values; dev_sel drops the next cycle with no ack required.
- Changing instruction or state while in SEL/WAIT has no effect; ch is latched.

Decomposition:
- F1/F2/F3 state codes stay in the shared parameters.v.
- Add to it: IOT opcode 3'o6, device code field width 6, word width 12, FSM state encodings.
- One natural sub-module: iot_prio_enc, an NDEV-bit lowest-index priority encoder with valid output. Instantiate it twice: once for address match, once for irq_dev.

Test Plan:
- Reset: assert reset for 2 cycles mid-WAIT -> all outputs 0, dev_sel=0, stall=0.
- Fast read: instruction 6036 at F2, dev_data[0]=12'o0215, dev_skip[0]=1, dev_clr_ac[0]=1 -> dev_sel=4'b0001 and iop=3'o6 for 1 cycle; then in_bus=0215, skip=1, clr_ac=1; bus_display=0215.
- Slow ack: instruction 6224 at F2, dev_ack[3] asserted 5 cycles into WAIT, dev_data[3]=12'o0070 -> stall high for 7 cycles; in_bus=0070; bus_display=latched ac.
- Timeout: instruction 6224 with no ack -> DONE after 15 WAIT cycles; in_bus=0, skip=0, timeout_err=1. Then IOT 6000 -> timeout_err=0.
- Unmatched and non-IOT: instruction 6554 and 1234 -> dev_sel=0, stall=0, in_bus=0, bus_display unchanged.
- Interrupts: dev_irq=4'b1010 with int_enable=1 -> irq=1 and irq_dev=1 next cycle. int_enable=0 -> irq=0 with irq_dev still 1.
